// File: rtl/croc_input_conditioner.sv
// croc_input_conditioner
//
// Brings NumChannels asynchronous pad inputs (fetch enable, GPIO, external
// interrupt lines) into the clk_i domain. The data path for each channel is:
//   SyncStages-deep synchroniser -> optional glitch filter -> edge detector
//   -> sticky interrupt-pending bit.
//
// Optional feature macro: CROC_INPUT_COND_IRQ_EN
//   defined   : pending flops and irq_o are implemented.
//   undefined : irq_pending_o / irq_o are tied low. The interrupt enable and
//               clear inputs stay on the port list but are ignored.
//
// Ports
//   clk_i          system clock (single clock domain)
//   rst_ni         asynchronous active-low reset
//   async_i        raw asynchronous inputs, one bit per channel
//   filter_en_i    per-channel filter enable (0 = bypass)
//   filter_len_i   extra stable cycles L required by the filter (shared)
//   rise_irq_en_i  per-channel rising-edge interrupt enable
//   fall_irq_en_i  per-channel falling-edge interrupt enable
//   irq_clear_i    write-1-clear of pending bits
//   level_o        synchronised, filtered level (registered)
//   rise_o         one-cycle pulse when level_o goes 0->1
//   fall_o         one-cycle pulse when level_o goes 1->0
//   irq_pending_o  sticky pending bits
//   irq_o          OR of all pending bits
module croc_input_conditioner #(
  parameter int unsigned              NumChannels = 16,
  parameter int unsigned              SyncStages  = 2,
  parameter int unsigned              FilterWidth = 4,
  parameter logic [NumChannels-1:0]   ResetValue  = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumChannels-1:0] async_i,
  input  logic [NumChannels-1:0] filter_en_i,
  input  logic [FilterWidth-1:0] filter_len_i,
  input  logic [NumChannels-1:0] rise_irq_en_i,
  input  logic [NumChannels-1:0] fall_irq_en_i,
  input  logic [NumChannels-1:0] irq_clear_i,
  output logic [NumChannels-1:0] level_o,
  output logic [NumChannels-1:0] rise_o,
  output logic [NumChannels-1:0] fall_o,
  output logic [NumChannels-1:0] irq_pending_o,
  output logic                   irq_o
);

  // Stage 0 is the flop that samples the pad; the last stage is the
  // metastability-settled value used by the filter.
  logic [SyncStages-1:0][NumChannels-1:0] sync_q;
  logic [NumChannels-1:0]                 sync;

  logic [NumChannels-1:0]                  level_q;
  logic [NumChannels-1:0]                  level_prev_q;
  logic [NumChannels-1:0][FilterWidth-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SyncStages{ResetValue}};
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], async_i};
    end
  end

  assign sync = sync_q[SyncStages-1];

  // The counter tracks how many cycles the synchronised input has already
  // disagreed with the accepted level. Comparing with >= (rather than ==)
  // means lowering filter_len_i below an in-flight count releases the new
  // level on the very next edge instead of stalling the channel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= ResetValue;
      cnt_q   <= '0;
    end else begin
      for (int i = 0; i < int'(NumChannels); i++) begin
        if (!filter_en_i[i]) begin
          level_q[i] <= sync[i];
          cnt_q[i]   <= '0;
        end else if (sync[i] == level_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] >= filter_len_i) begin
          level_q[i] <= sync[i];
          cnt_q[i]   <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + FilterWidth'(1);
        end
      end
    end
  end

  // level_prev_q resets to ResetValue as well, so no spurious edge is
  // reported straight out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_prev_q <= ResetValue;
    end else begin
      level_prev_q <= level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_q & ~level_prev_q;
  assign fall_o  = ~level_q & level_prev_q;

`ifdef CROC_INPUT_COND_IRQ_EN
  logic [NumChannels-1:0] pending_q;
  logic [NumChannels-1:0] irq_set;

  assign irq_set = (rise_o & rise_irq_en_i) | (fall_o & fall_irq_en_i);

  // A new event and a clear in the same cycle leave the bit set, so an
  // edge arriving while software acknowledges an older one is not lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else begin
      pending_q <= irq_set | (pending_q & ~irq_clear_i);
    end
  end

  assign irq_pending_o = pending_q;
  assign irq_o         = |pending_q;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{rise_irq_en_i, fall_irq_en_i, irq_clear_i};

  assign irq_pending_o = '0;
  assign irq_o         = 1'b0;
`endif

endmodule
